// File: rtl/bu_pkg.sv
// Shared butterfly-unit definitions for the word-level Montgomery reducer.
package bu_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      SUB,
      DONE
   } wordred_state_e;

   localparam int unsigned Q_W_DEF = 64;
   localparam int unsigned W_DEF   = 16;
   localparam int unsigned L_DEF   = 4;

   // qH for the Goldilocks prime q = 2^64 - 2^32 + 1
   localparam logic [63:0] GOLDILOCKS_QH = 64'h0000_FFFF_FFFF_0000;

endpackage

// File: rtl/wordred_seq_if.sv
// Operation/result handshake bundle for wordred_seq.
interface wordred_seq_if
   import bu_pkg::*;
#(
   parameter int unsigned Q_W   = Q_W_DEF,
   parameter int unsigned W     = W_DEF,
   parameter int unsigned TAG_W = 8
);

   logic                 in_valid;
   logic                 in_ready;
   logic [2*Q_W-1:0]     in_c;
   logic [Q_W-W-1:0]     in_qh;
   logic [TAG_W-1:0]     in_tag;
   logic                 out_valid;
   logic                 out_ready;
   logic [Q_W:0]         out_t;
   logic [TAG_W-1:0]     out_tag;

   modport master (
      output in_valid, in_c, in_qh, in_tag, out_ready,
      input  in_ready, out_valid, out_t, out_tag
   );

   modport slave (
      input  in_valid, in_c, in_qh, in_tag, out_ready,
      output in_ready, out_valid, out_t, out_tag
   );

endinterface

// File: rtl/wordred_step.sv
// One combinational Montgomery word step: acc' = (acc >> W) + qH*m + (cl != 0).
module wordred_step
   import bu_pkg::*;
#(
   parameter int unsigned Q_W = Q_W_DEF,
   parameter int unsigned W   = W_DEF
)
(
   input  logic [2*Q_W:0]   acc_in,
   input  logic [Q_W-W-1:0] qh,
   output logic [2*Q_W:0]   acc_out
);

   localparam int unsigned AW = 2*Q_W + 1;

   logic [W-1:0] w_cl;
   logic [W-1:0] w_m;
   logic         w_carry;
   (* use_dsp = "yes" *) logic [Q_W-1:0] w_prod;

   // cl + m == 2^W whenever cl != 0, so the carry restores the exact division
   always_comb begin
      w_cl    = acc_in[W-1:0];
      w_m     = '0 - w_cl;
      w_carry = |w_cl;
      w_prod  = Q_W'(qh) * Q_W'(w_m);
      acc_out = AW'(acc_in[AW-1:W]) + AW'(w_prod) + AW'(w_carry);
   end

endmodule

// File: rtl/wordred_seq.sv
// Iterative valid/ready Montgomery reducer: T = C * 2^(-W*L) mod q, optional final subtract.
module wordred_seq
   import bu_pkg::*;
#(
   parameter int unsigned Q_W       = Q_W_DEF,
   parameter int unsigned W         = W_DEF,
   parameter int unsigned L         = L_DEF,
   parameter int unsigned FINAL_SUB = 1,
   parameter int unsigned TAG_W     = 8
)
(
   input  logic          clk,
   input  logic          rst_n,
   wordred_seq_if.slave  bus
);

   localparam int unsigned AW  = 2*Q_W + 1;
   localparam int unsigned OW  = Q_W + 1;
   localparam int unsigned QHW = Q_W - W;
   localparam int unsigned SW  = $clog2(L + 1);

   wordred_state_e   r_state;
   wordred_state_e   w_state_nxt;
   logic [AW-1:0]    r_acc;
   logic [AW-1:0]    w_acc_step;
   logic [QHW-1:0]   r_qh;
   logic [TAG_W-1:0] r_tag;
   logic [SW-1:0]    r_step;
   logic [OW-1:0]    r_out_t;
   logic [TAG_W-1:0] r_out_tag;

   logic             w_accept;
   logic             w_last;
   logic             w_load_out;
   logic [Q_W-1:0]   w_q;
   logic             w_ge;
   logic [OW-1:0]    w_out_val;

   wordred_step #(
      .Q_W (Q_W),
      .W   (W)
   ) u_step (
      .acc_in  (r_acc),
      .qh      (r_qh),
      .acc_out (w_acc_step)
   );

   // Without the final subtract, the last step's sum goes straight to the output
   always_comb begin
      w_q    = {r_qh, {(W-1){1'b0}}, 1'b1};
      w_ge   = (r_acc >= AW'(w_q));
      w_last = (r_step == SW'(L - 1));
      if (FINAL_SUB != 0) begin
         w_out_val = w_ge ? OW'(r_acc - AW'(w_q)) : OW'(r_acc);
      end else begin
         w_out_val = OW'(w_acc_step);
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_accept      = 1'b0;
      w_load_out    = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.in_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            if (w_last) begin
               w_state_nxt = (FINAL_SUB != 0) ? SUB : DONE;
               w_load_out  = (FINAL_SUB == 0);
            end
         end
         SUB: begin
            w_load_out  = 1'b1;
            w_state_nxt = DONE;
         end
         DONE: begin
            if (bus.out_ready) begin
               if (bus.in_valid) begin
                  w_accept    = 1'b1;
                  w_state_nxt = RUN;
               end else begin
                  w_state_nxt = IDLE;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
      bus.in_ready  = rst_n & ((r_state == IDLE) | ((r_state == DONE) & bus.out_ready));
      bus.out_valid = (r_state == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc     <= '0;
         r_qh      <= '0;
         r_tag     <= '0;
         r_step    <= '0;
         r_out_t   <= '0;
         r_out_tag <= '0;
      end else begin
         if (w_accept) begin
            r_acc  <= AW'(bus.in_c);
            r_qh   <= bus.in_qh;
            r_tag  <= bus.in_tag;
            r_step <= '0;
         end else if (r_state == RUN) begin
            r_acc  <= w_acc_step;
            r_step <= r_step + SW'(1);
         end
         if (w_load_out) begin
            r_out_t   <= w_out_val;
            r_out_tag <= r_tag;
         end
      end
   end

   assign bus.out_t   = r_out_t;
   assign bus.out_tag = r_out_tag;

endmodule

// File: tb/tb_wordred_seq.sv
// Directed and streamed checks of wordred_seq on the Goldilocks prime, FINAL_SUB=1 and 0.
module tb_wordred_seq;

   localparam int unsigned QW = 64;
   localparam int unsigned WW = 16;
   localparam int unsigned TW = 8;
   localparam logic [63:0]  Q     = 64'hFFFF_FFFF_0000_0001;
   localparam logic [47:0]  QH    = 48'hFFFF_FFFF_0000;
   localparam logic [63:0]  INV64 = 64'hFFFF_FFFE_0000_0001;
   localparam logic [127:0] C_2P64 = {64'h1, 64'h0};

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   wordred_seq_if #(.Q_W(QW), .W(WW), .TAG_W(TW)) bus1 ();
   wordred_seq_if #(.Q_W(QW), .W(WW), .TAG_W(TW)) bus0 ();

   wordred_seq #(
      .Q_W(QW), .W(WW), .L(4), .FINAL_SUB(1), .TAG_W(TW)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(bus1)
   );

   wordred_seq #(
      .Q_W(QW), .W(WW), .L(4), .FINAL_SUB(0), .TAG_W(TW)
   ) u_dut_nosub (
      .clk(clk), .rst_n(rst_n), .bus(bus0)
   );

   // Reference: C mod q times the known inverse of 2^64
   function automatic logic [63:0] model(input logic [127:0] c);
      logic [127:0] r;
      r = c % {64'h0, Q};
      r = r * {64'h0, INV64};
      r = r % {64'h0, Q};
      return r[63:0];
   endfunction

   task automatic run_op(input logic [127:0] c, input logic [7:0] tag,
                         output int lat, output logic [64:0] t, output logic [7:0] tg);
      @(negedge clk);
      bus1.in_c = c; bus1.in_qh = QH; bus1.in_tag = tag;
      bus1.in_valid = 1'b1; bus1.out_ready = 1'b0;
      @(posedge clk); #1;
      bus1.in_valid = 1'b0;
      lat = 0;
      while (!bus1.out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      t = bus1.out_t; tg = bus1.out_tag;
      @(negedge clk); bus1.out_ready = 1'b1;
      @(posedge clk); #1;
      bus1.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      n_checks++; if (bus1.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", bus1.in_ready); end
      n_checks++; if (bus1.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus1.out_valid); end
      n_checks++; if (bus1.out_t !== 65'h0) begin n_fail++; $display("FAIL reset_out_t: got %h expected 0", bus1.out_t); end
      n_checks++; if (bus1.out_tag !== 8'h0) begin n_fail++; $display("FAIL reset_out_tag: got %h expected 0", bus1.out_tag); end
      @(negedge clk); rst_n = 1'b1;
      #1;
      n_checks++; if (bus1.in_ready !== 1'b1) begin n_fail++; $display("FAIL idle_in_ready: got %b expected 1", bus1.in_ready); end
   endtask

   task automatic test_vectors();
      logic [127:0] vc [5];
      logic [63:0]  ve [5];
      int           lat;
      logic [64:0]  t;
      logic [7:0]   tg;
      vc[0] = C_2P64;                                          ve[0] = 64'h1;
      vc[1] = 128'h1;                                          ve[1] = 64'hFFFF_FFFE_0000_0001;
      vc[2] = 128'h0;                                          ve[2] = 64'h0;
      vc[3] = 128'h1_0000_0000;                                ve[3] = 64'hFFFF_FFFE_0000_0002;
      vc[4] = 128'hFFFF_FFFF_0000_0000_FFFF_FFFF_FFFF_FFFF;    ve[4] = 64'h1_0000_0000;
      for (int i = 0; i < 5; i++) begin
         run_op(vc[i], 8'(8'h10 + i), lat, t, tg);
         n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL vec%0d_latency: got %0d expected 5", i, lat); end
         n_checks++; if (t !== {1'b0, ve[i]}) begin n_fail++; $display("FAIL vec%0d_out_t: got %h expected %h", i, t, ve[i]); end
         n_checks++; if (tg !== 8'(8'h10 + i)) begin n_fail++; $display("FAIL vec%0d_tag: got %h expected %h", i, tg, 8'(8'h10 + i)); end
      end
   endtask

   task automatic test_final_sub();
      int          lat1;
      int          lat0;
      logic [64:0] t1;
      logic [64:0] t0;
      logic [7:0]  g1;
      logic [7:0]  g0;
      lat1 = -1; lat0 = -1; t1 = '0; t0 = '0; g1 = '0; g0 = '0;
      @(negedge clk);
      bus1.in_c = {64'h0, Q}; bus1.in_qh = QH; bus1.in_tag = 8'h33; bus1.in_valid = 1'b1;
      bus0.in_c = {64'h0, Q}; bus0.in_qh = QH; bus0.in_tag = 8'h34; bus0.in_valid = 1'b1;
      @(posedge clk); #1;
      bus1.in_valid = 1'b0; bus0.in_valid = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         @(posedge clk); #1;
         if (lat1 < 0 && bus1.out_valid) begin lat1 = i; t1 = bus1.out_t; g1 = bus1.out_tag; end
         if (lat0 < 0 && bus0.out_valid) begin lat0 = i; t0 = bus0.out_t; g0 = bus0.out_tag; end
      end
      n_checks++; if (lat1 !== 5) begin n_fail++; $display("FAIL q_sub_latency: got %0d expected 5", lat1); end
      n_checks++; if (t1 !== 65'h0) begin n_fail++; $display("FAIL q_sub_out_t: got %h expected 0", t1); end
      n_checks++; if (g1 !== 8'h33) begin n_fail++; $display("FAIL q_sub_tag: got %h expected 33", g1); end
      n_checks++; if (lat0 !== 4) begin n_fail++; $display("FAIL q_nosub_latency: got %0d expected 4", lat0); end
      n_checks++; if (t0 !== {1'b0, Q}) begin n_fail++; $display("FAIL q_nosub_out_t: got %h expected %h", t0, Q); end
      n_checks++; if (g0 !== 8'h34) begin n_fail++; $display("FAIL q_nosub_tag: got %h expected 34", g0); end
      @(negedge clk); bus1.out_ready = 1'b1; bus0.out_ready = 1'b1;
      @(posedge clk); #1;
      bus1.out_ready = 1'b0; bus0.out_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      int cnt;
      @(negedge clk);
      bus1.in_c = C_2P64; bus1.in_qh = QH; bus1.in_tag = 8'h44; bus1.in_valid = 1'b1; bus1.out_ready = 1'b0;
      @(posedge clk); #1;
      bus1.in_valid = 1'b0;
      cnt = 0;
      while (!bus1.out_valid && cnt < 20) begin @(posedge clk); #1; cnt++; end
      n_checks++; if (bus1.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_first_valid: got %b expected 1", bus1.out_valid); end
      @(negedge clk);
      bus1.in_c = 128'h1; bus1.in_tag = 8'h66; bus1.in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         n_checks++; if (bus1.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid c%0d: got %b expected 1", i, bus1.out_valid); end
         n_checks++; if (bus1.out_t !== 65'h1) begin n_fail++; $display("FAIL bp_hold_out_t c%0d: got %h expected 1", i, bus1.out_t); end
         n_checks++; if (bus1.out_tag !== 8'h44) begin n_fail++; $display("FAIL bp_hold_tag c%0d: got %h expected 44", i, bus1.out_tag); end
         n_checks++; if (bus1.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_in_ready c%0d: got %b expected 0", i, bus1.in_ready); end
      end
      @(negedge clk);
      bus1.in_tag = 8'h55; bus1.out_ready = 1'b1;
      #1;
      n_checks++; if (bus1.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready: got %b expected 1", bus1.in_ready); end
      @(posedge clk); #1;
      bus1.in_valid = 1'b0; bus1.out_ready = 1'b0;
      n_checks++; if (bus1.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_after_take_valid: got %b expected 0", bus1.out_valid); end
      cnt = 0;
      while (!bus1.out_valid && cnt < 20) begin @(posedge clk); #1; cnt++; end
      n_checks++; if (cnt !== 5) begin n_fail++; $display("FAIL bp_next_latency: got %0d expected 5", cnt); end
      n_checks++; if (bus1.out_t !== 65'h0_FFFF_FFFE_0000_0001) begin n_fail++; $display("FAIL bp_next_out_t: got %h expected FFFFFFFE00000001", bus1.out_t); end
      n_checks++; if (bus1.out_tag !== 8'h55) begin n_fail++; $display("FAIL bp_next_tag: got %h expected 55", bus1.out_tag); end
      @(negedge clk); bus1.out_ready = 1'b1;
      @(posedge clk); #1;
      bus1.out_ready = 1'b0;
      @(posedge clk); #1;
      n_checks++; if (bus1.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_ignored_op: got out_valid %b expected 0", bus1.out_valid); end
   endtask

   task automatic test_stream();
      logic [64:0]  exp_q [$];
      logic [7:0]   tag_q [$];
      logic [63:0]  hi;
      logic [63:0]  lo;
      logic [127:0] c;
      logic [64:0]  cur_exp;
      logic [7:0]   cur_tag;
      logic [64:0]  e;
      logic [7:0]   et;
      bit           have_item;
      int           sent;
      int           rcvd;
      int           cyc;
      have_item = 0; sent = 0; rcvd = 0; cyc = 0; cur_exp = '0; cur_tag = '0;
      while (rcvd < 100 && cyc < 5000) begin
         @(negedge clk);
         cyc++;
         if (!have_item) begin
            if (sent < 100 && $urandom_range(0, 3) != 0) begin
               hi = {$urandom(), $urandom()};
               if (hi >= Q) hi = hi - Q;
               lo = {$urandom(), $urandom()};
               c = {hi, lo};
               cur_exp = {1'b0, model(c)};
               cur_tag = 8'($urandom_range(0, 255));
               bus1.in_c = c; bus1.in_qh = QH; bus1.in_tag = cur_tag; bus1.in_valid = 1'b1;
               have_item = 1;
            end else begin
               bus1.in_valid = 1'b0;
            end
         end
         bus1.out_ready = 1'($urandom_range(0, 1));
         #1;
         if (bus1.out_valid && bus1.out_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL stream_unexpected: got result %h with nothing outstanding", bus1.out_t);
            end else begin
               e = exp_q.pop_front();
               et = tag_q.pop_front();
               n_checks++; if (bus1.out_t !== e) begin n_fail++; $display("FAIL stream_out_t #%0d: got %h expected %h", rcvd, bus1.out_t, e); end
               n_checks++; if (bus1.out_tag !== et) begin n_fail++; $display("FAIL stream_tag #%0d: got %h expected %h", rcvd, bus1.out_tag, et); end
               rcvd++;
            end
         end
         if (have_item && bus1.in_ready) begin
            exp_q.push_back(cur_exp);
            tag_q.push_back(cur_tag);
            sent++;
            have_item = 0;
         end
      end
      n_checks++; if (rcvd !== 100) begin n_fail++; $display("FAIL stream_count: got %0d results expected 100", rcvd); end
      @(negedge clk);
      bus1.in_valid = 1'b0; bus1.out_ready = 1'b1;
      @(posedge clk); #1;
      bus1.out_ready = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      int          lat;
      int          seen;
      logic [64:0] t;
      logic [7:0]  tg;
      @(negedge clk);
      bus1.in_c = 128'h1; bus1.in_qh = QH; bus1.in_tag = 8'h77; bus1.in_valid = 1'b1; bus1.out_ready = 1'b0;
      @(posedge clk); #1;
      bus1.in_valid = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      n_checks++; if (bus1.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_out_valid: got %b expected 0", bus1.out_valid); end
      n_checks++; if (bus1.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_in_ready: got %b expected 0", bus1.in_ready); end
      n_checks++; if (bus1.out_t !== 65'h0) begin n_fail++; $display("FAIL rst_mid_out_t: got %h expected 0", bus1.out_t); end
      n_checks++; if (bus1.out_tag !== 8'h0) begin n_fail++; $display("FAIL rst_mid_out_tag: got %h expected 0", bus1.out_tag); end
      @(negedge clk); rst_n = 1'b1;
      #1;
      n_checks++; if (bus1.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_idle: got in_ready %b expected 1", bus1.in_ready); end
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (bus1.out_valid) seen++;
      end
      n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL rst_abandoned: got %0d valid cycles expected 0", seen); end
      run_op(C_2P64, 8'h78, lat, t, tg);
      n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL rst_after_latency: got %0d expected 5", lat); end
      n_checks++; if (t !== 65'h1) begin n_fail++; $display("FAIL rst_after_out_t: got %h expected 1", t); end
      n_checks++; if (tg !== 8'h78) begin n_fail++; $display("FAIL rst_after_tag: got %h expected 78", tg); end
   endtask

   initial begin
      bus1.in_valid = 1'b0; bus1.in_c = '0; bus1.in_qh = QH; bus1.in_tag = '0; bus1.out_ready = 1'b0;
      bus0.in_valid = 1'b0; bus0.in_c = '0; bus0.in_qh = QH; bus0.in_tag = '0; bus0.out_ready = 1'b0;
      test_reset();
      test_vectors();
      test_final_sub();
      test_backpressure();
      test_stream();
      test_reset_mid_run();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
